// File: rtl/alu_pkg.sv
// Shared ALU datapath types and widths for the RV32 execute stage.
package alu_pkg;
   localparam int XLEN    = 32;
   localparam int SHAMT_W = 5;
   typedef logic [XLEN-1:0] word_t;
endpackage

// File: rtl/sll_stage.sv
// One stage of the logarithmic left shifter: shifts by a fixed SHIFT when en is set.
module sll_stage #(
   parameter int WIDTH = 32,
   parameter int SHIFT = 1
) (
   input  logic [WIDTH-1:0] din,
   input  logic             en,
   output logic [WIDTH-1:0] dout
);
   assign dout = en ? (din << SHIFT) : din;
endmodule

// File: rtl/shift_left_logical_unit.sv
// Logical left shifter with a full-width shift amount; any amount >= WIDTH yields zero.
// The output is combinational by default, or registered when REGISTERED=1.
module shift_left_logical_unit
   import alu_pkg::*;
#(
   parameter bit REGISTERED = 1'b0,
   parameter int WIDTH      = XLEN
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] rs1_i,
   input  logic [WIDTH-1:0] rs2_i,
   output logic [WIDTH-1:0] rd_o
);
   localparam int SHAMT = $clog2(WIDTH);

   logic [SHAMT:0][WIDTH-1:0] chain;
   logic                      over;
   logic [WIDTH-1:0]          shifted;

   assign chain[0] = rs1_i;

   genvar k;
   generate
      for (k = 0; k < SHAMT; k++) begin : g_stage
         sll_stage #(.WIDTH(WIDTH), .SHIFT(1 << k)) u_stage (
            .din  (chain[k]),
            .en   (rs2_i[k]),
            .dout (chain[k+1])
         );
      end
   endgenerate

   // Upper amount bits are not masked: any of them set forces zero.
   assign over    = |rs2_i[WIDTH-1:SHAMT];
   assign shifted = over ? '0 : chain[SHAMT];

   generate
      if (REGISTERED) begin : g_reg
         logic [WIDTH-1:0] rd_q;
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) rd_q <= '0;
            else       rd_q <= shifted;
         end
         assign rd_o = rd_q;
      end else begin : g_comb
         logic unused_clk_rst;
         assign unused_clk_rst = &{1'b0, clk_i, rst_i};
         assign rd_o = shifted;
      end
   endgenerate
endmodule

// File: tb/tb_shift_left_logical_unit.sv
// Directed and random checks for shift_left_logical_unit, combinational and registered builds.
module tb_shift_left_logical_unit;
   logic        clk = 1'b0;
   logic        rst_c = 1'b1;   // comb build: reset held high, must be ignored
   logic        rst_r = 1'b1;
   logic [31:0] rs1_c = '0, rs2_c = '0, rd_c;
   logic [31:0] rs1_r = '0, rs2_r = '0, rd_r;
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   shift_left_logical_unit #(.REGISTERED(1'b0), .WIDTH(32)) u_comb (
      .clk_i(clk), .rst_i(rst_c), .rs1_i(rs1_c), .rs2_i(rs2_c), .rd_o(rd_c)
   );

   shift_left_logical_unit #(.REGISTERED(1'b1), .WIDTH(32)) u_reg (
      .clk_i(clk), .rst_i(rst_r), .rs1_i(rs1_r), .rs2_i(rs2_r), .rd_o(rd_r)
   );

   task automatic test_reset;
      #1;
      checks++;
      if (rd_r !== 32'h0) begin
         errors++;
         $display("FAIL reset_initial: got %h expected %h", rd_r, 32'h0);
      end
      rs1_r = 32'hFFFF_FFFF;
      rs2_r = 32'h0;
      @(posedge clk); #1;
      checks++;
      if (rd_r !== 32'h0) begin
         errors++;
         $display("FAIL reset_hold_edge: got %h expected %h", rd_r, 32'h0);
      end
   endtask

   task automatic test_directed;
      logic [31:0] a [8] = '{32'h0000_0001, 32'h0000_0001, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hDEAD_BEEF};
      logic [31:0] b [8] = '{32'd31, 32'd0, 32'd4, 32'd16,
                             32'd32, 32'hFFFF_FFFB, 32'h8000_0001, 32'd1};
      logic [31:0] e [8] = '{32'h8000_0000, 32'h0000_0001, 32'hEADB_EEF0, 32'hBEEF_0000,
                             32'h0, 32'h0, 32'h0, 32'hBD5B_7DDE};
      for (int i = 0; i < 8; i++) begin
         rs1_c = a[i];
         rs2_c = b[i];
         #1;
         checks++;
         if (rd_c !== e[i]) begin
            errors++;
            $display("FAIL directed[%0d] rs1=%h rs2=%h: got %h expected %h", i, a[i], b[i], rd_c, e[i]);
         end
      end
   endtask

   task automatic test_comb_clk_ignored;
      rs1_c = 32'h1234_5678;
      rs2_c = 32'd8;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (rd_c !== 32'h3456_7800) begin
            errors++;
            $display("FAIL comb_clk_rst[%0d]: got %h expected %h", i, rd_c, 32'h3456_7800);
         end
      end
   endtask

   task automatic test_registered;
      @(negedge clk);
      rst_r = 1'b0;
      rs1_r = 32'h1234_5678;
      rs2_r = 32'd8;
      #1;
      checks++;
      if (rd_r !== 32'h0) begin
         errors++;
         $display("FAIL reg_before_edge: got %h expected %h", rd_r, 32'h0);
      end
      @(posedge clk); #1;
      checks++;
      if (rd_r !== 32'h3456_7800) begin
         errors++;
         $display("FAIL reg_after_edge: got %h expected %h", rd_r, 32'h3456_7800);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] a [3] = '{32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h0000_0001};
      logic [31:0] b [3] = '{32'd4, 32'd32, 32'd31};
      logic [31:0] e [3] = '{32'hEADB_EEF0, 32'h0, 32'h8000_0000};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         rs1_r = a[i];
         rs2_r = b[i];
         @(posedge clk); #1;
         checks++;
         if (rd_r !== e[i]) begin
            errors++;
            $display("FAIL reg_b2b[%0d]: got %h expected %h", i, rd_r, e[i]);
         end
      end
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      rs1_r = 32'h0000_0001;
      rs2_r = 32'd0;
      #1 rst_r = 1'b1;
      #1;
      checks++;
      if (rd_r !== 32'h0) begin
         errors++;
         $display("FAIL mid_reset_async: got %h expected %h", rd_r, 32'h0);
      end
      @(posedge clk); #1;
      checks++;
      if (rd_r !== 32'h0) begin
         errors++;
         $display("FAIL mid_reset_held: got %h expected %h", rd_r, 32'h0);
      end
      @(negedge clk);
      rst_r = 1'b0;
      #1;
      checks++;
      if (rd_r !== 32'h0) begin
         errors++;
         $display("FAIL mid_reset_released: got %h expected %h", rd_r, 32'h0);
      end
      @(posedge clk); #1;
      checks++;
      if (rd_r !== 32'h0000_0001) begin
         errors++;
         $display("FAIL mid_reset_first_edge: got %h expected %h", rd_r, 32'h0000_0001);
      end
   endtask

   task automatic test_random;
      logic [31:0] exp_v;
      for (int i = 0; i < 150; i++) begin
         rs1_c = $urandom;
         rs2_c = 32'($signed($urandom) % 32);
         exp_v = rs1_c << rs2_c;
         #1;
         checks++;
         if (rd_c !== exp_v) begin
            errors++;
            $display("FAIL random[%0d] rs1=%h rs2=%h: got %h expected %h", i, rs1_c, rs2_c, rd_c, exp_v);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $fatal(1, "random sweep stopped");
         end
      end
   endtask

   initial begin
      test_reset;
      test_directed;
      test_comb_clk_ignored;
      test_registered;
      test_back_to_back;
      test_reset_mid;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
